// File: rtl/axi4l_param_loader_if.sv
// AXI4-Lite bus between the parameter loader (master) and the aligner register slave.
// Carries the five AXI4-Lite channels only; clock and reset stay plain ports.
// The master modport drives AW/W/AR payloads and valids plus B/R readies.
interface axi4l_param_loader_if #(
  parameter int ADDR_W = 8
) ();

  // Write address channel
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [2:0]        m_axi_awprot;
  logic              m_axi_awvalid;
  logic              m_axi_awready;

  // Write data channel
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;

  // Write response channel
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;

  // Read address channel
  logic [ADDR_W-1:0] m_axi_araddr;
  logic [2:0]        m_axi_arprot;
  logic              m_axi_arvalid;
  logic              m_axi_arready;

  // Read data channel
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/axi4l_param_loader.sv
// AXI4-Lite master turning a command stream into single register writes/reads, one at a time.
// Latency: command acceptance to rsp_valid is 3 cycles against a zero-wait slave (write or read).
// Backpressure: cmd_ready only in IDLE; the response is held until rsp_ready.
// Optional readback verify of every OKAY write is enabled by defining PARAM_LOADER_VERIFY_EN.
module axi4l_param_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                s_axi_aclk,
  input  logic                rst,
  // command stream
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [31:0]         cmd_data,
  input  logic [31:0]         cmd_vmask,
  // response stream
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic [2:0]          rsp_err,
  // status
  output logic                busy,
  output logic                timeout_flag,
  // AXI4-Lite master bus
  axi4l_param_loader_if.master m_axi
);

  // TIMEOUT >= 2, so TIMEOUT-1 always fits in CNT_W bits.
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WA   = 3'd1,
    S_WB   = 3'd2,
    S_RA   = 3'd3,
    S_RD   = 3'd4,
    S_RSP  = 3'd5
`ifdef PARAM_LOADER_VERIFY_EN
    ,
    S_VRA  = 3'd6,
    S_VRD  = 3'd7
`endif
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // registered outputs and captured command
  logic              r_awvalid, w_awvalid_nxt;
  logic              r_wvalid,  w_wvalid_nxt;
  logic              r_bready,  w_bready_nxt;
  logic              r_arvalid, w_arvalid_nxt;
  logic              r_rready,  w_rready_nxt;
  logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
  logic [31:0]       r_wdata,   w_wdata_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]       r_rsp_data,  w_rsp_data_nxt;
  logic [2:0]        r_rsp_err,   w_rsp_err_nxt;
  logic              r_tmo_flag,  w_tmo_flag_nxt;
  logic [CNT_W-1:0]  r_tcnt;

`ifdef PARAM_LOADER_VERIFY_EN
  logic [31:0]       r_vmask, w_vmask_nxt;
  logic              w_verify_mis;
`else
  // The compare mask only matters for readback verify.
  logic              w_unused_vmask;
  assign w_unused_vmask = ^cmd_vmask;
`endif

  logic              w_accept;
  logic              w_aw_done;
  logic              w_w_done;
  logic              w_wait;
  logic              w_done;
  logic              w_tmo;
  logic              w_abort;
  logic              w_bresp_ok;

  assign cmd_ready = (r_state == S_IDLE) & ~rst;
  assign w_accept  = cmd_valid & cmd_ready;

  // A write channel is finished once its valid has dropped or handshakes this cycle.
  assign w_aw_done  = ~r_awvalid | m_axi.m_axi_awready;
  assign w_w_done   = ~r_wvalid  | m_axi.m_axi_wready;
  assign w_bresp_ok = (m_axi.m_axi_bresp == 2'b00);

`ifdef PARAM_LOADER_VERIFY_EN
  assign w_verify_mis = |((m_axi.m_axi_rdata ^ r_wdata) & r_vmask);
`endif

  // Classify the current state: is it waiting on the slave, and does the slave finish it now.
  always_comb begin
    w_wait = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_WA: begin
        w_wait = 1'b1;
        w_done = w_aw_done & w_w_done;
      end
      S_WB: begin
        w_wait = 1'b1;
        w_done = m_axi.m_axi_bvalid;
      end
`ifdef PARAM_LOADER_VERIFY_EN
      S_RA, S_VRA: begin
`else
      S_RA: begin
`endif
        w_wait = 1'b1;
        w_done = m_axi.m_axi_arready;
      end
`ifdef PARAM_LOADER_VERIFY_EN
      S_RD, S_VRD: begin
`else
      S_RD: begin
`endif
        w_wait = 1'b1;
        w_done = m_axi.m_axi_rvalid;
      end
      default: begin
        w_wait = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // A slave that completes in the last allowed cycle still wins over the timeout.
  assign w_tmo   = w_wait & (r_tcnt == TMO_LAST);
  assign w_abort = w_tmo & ~w_done;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = cmd_wr ? S_WA : S_RA;
      S_WA: begin
        if (w_abort)     w_state_nxt = S_RSP;
        else if (w_done) w_state_nxt = S_WB;
      end
      S_WB: begin
        if (w_abort) w_state_nxt = S_RSP;
`ifdef PARAM_LOADER_VERIFY_EN
        else if (w_done) w_state_nxt = w_bresp_ok ? S_VRA : S_RSP;
`else
        else if (w_done) w_state_nxt = S_RSP;
`endif
      end
      S_RA: begin
        if (w_abort)     w_state_nxt = S_RSP;
        else if (w_done) w_state_nxt = S_RD;
      end
      S_RD: begin
        if (w_abort)     w_state_nxt = S_RSP;
        else if (w_done) w_state_nxt = S_RSP;
      end
`ifdef PARAM_LOADER_VERIFY_EN
      S_VRA: begin
        if (w_abort)     w_state_nxt = S_RSP;
        else if (w_done) w_state_nxt = S_VRD;
      end
      S_VRD: begin
        if (w_abort)     w_state_nxt = S_RSP;
        else if (w_done) w_state_nxt = S_RSP;
      end
`endif
      S_RSP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered bus/response outputs, decided by state and slave handshakes.
  always_comb begin
    w_awvalid_nxt   = r_awvalid;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_tmo_flag_nxt  = r_tmo_flag;
`ifdef PARAM_LOADER_VERIFY_EN
    w_vmask_nxt     = r_vmask;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr_nxt     = {cmd_addr[ADDR_W-1:2], 2'b00};
          w_wdata_nxt    = cmd_data;
          w_rsp_data_nxt = 32'h0;
          w_rsp_err_nxt  = 3'b000;
          w_awvalid_nxt  = cmd_wr;
          w_wvalid_nxt   = cmd_wr;
          w_arvalid_nxt  = ~cmd_wr;
`ifdef PARAM_LOADER_VERIFY_EN
          w_vmask_nxt    = cmd_vmask;
`endif
        end
      end
      S_WA: begin
        if (m_axi.m_axi_awready) w_awvalid_nxt = 1'b0;
        if (m_axi.m_axi_wready)  w_wvalid_nxt  = 1'b0;
        if (w_done)              w_bready_nxt  = 1'b1;
      end
      S_WB: begin
        if (m_axi.m_axi_bvalid) begin
          w_bready_nxt     = 1'b0;
          w_rsp_err_nxt[0] = ~w_bresp_ok;
`ifdef PARAM_LOADER_VERIFY_EN
          if (w_bresp_ok) w_arvalid_nxt   = 1'b1;
          else            w_rsp_valid_nxt = 1'b1;
`else
          w_rsp_valid_nxt  = 1'b1;
`endif
        end
      end
`ifdef PARAM_LOADER_VERIFY_EN
      S_RA, S_VRA: begin
`else
      S_RA: begin
`endif
        if (m_axi.m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
        end
      end
      S_RD: begin
        if (m_axi.m_axi_rvalid) begin
          w_rready_nxt     = 1'b0;
          w_rsp_data_nxt   = m_axi.m_axi_rdata;
          w_rsp_err_nxt[0] = (m_axi.m_axi_rresp != 2'b00);
          w_rsp_valid_nxt  = 1'b1;
        end
      end
`ifdef PARAM_LOADER_VERIFY_EN
      S_VRD: begin
        if (m_axi.m_axi_rvalid) begin
          w_rready_nxt     = 1'b0;
          w_rsp_data_nxt   = m_axi.m_axi_rdata;
          w_rsp_err_nxt[0] = r_rsp_err[0] | (m_axi.m_axi_rresp != 2'b00);
          w_rsp_err_nxt[2] = w_verify_mis;
          w_rsp_valid_nxt  = 1'b1;
        end
      end
`endif
      S_RSP: begin
        if (rsp_ready) w_rsp_valid_nxt = 1'b0;
      end
      default: begin
        w_rsp_valid_nxt = r_rsp_valid;
      end
    endcase
    // Timeout abandons the bus: everything released, error reported, flag latched.
    if (w_abort) begin
      w_awvalid_nxt    = 1'b0;
      w_wvalid_nxt     = 1'b0;
      w_bready_nxt     = 1'b0;
      w_arvalid_nxt    = 1'b0;
      w_rready_nxt     = 1'b0;
      w_rsp_err_nxt[1] = 1'b1;
      w_rsp_valid_nxt  = 1'b1;
      w_tmo_flag_nxt   = 1'b1;
    end
  end

  // State, output and timeout-counter registers with synchronous reset.
  always_ff @(posedge s_axi_aclk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'h0;
      r_rsp_err   <= 3'b000;
      r_tmo_flag  <= 1'b0;
      r_tcnt      <= '0;
`ifdef PARAM_LOADER_VERIFY_EN
      r_vmask     <= 32'h0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_tmo_flag  <= w_tmo_flag_nxt;
`ifdef PARAM_LOADER_VERIFY_EN
      r_vmask     <= w_vmask_nxt;
`endif
      // Counter restarts on every state change, so it measures time spent in the current wait.
      if (w_state_nxt != r_state) r_tcnt <= '0;
      else if (w_wait)            r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign m_axi.m_axi_awaddr  = r_addr;
  assign m_axi.m_axi_awprot  = 3'b000;
  assign m_axi.m_axi_awvalid = r_awvalid;
  assign m_axi.m_axi_wdata   = r_wdata;
  assign m_axi.m_axi_wstrb   = 4'hF;
  assign m_axi.m_axi_wvalid  = r_wvalid;
  assign m_axi.m_axi_bready  = r_bready;
  assign m_axi.m_axi_araddr  = r_addr;
  assign m_axi.m_axi_arprot  = 3'b000;
  assign m_axi.m_axi_arvalid = r_arvalid;
  assign m_axi.m_axi_rready  = r_rready;

  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign rsp_err      = r_rsp_err;
  assign busy         = (r_state != S_IDLE);
  assign timeout_flag = r_tmo_flag;

endmodule
